demux_stream_1ton: RTL and testbench
====================================

Name: demux_stream_1toN

Overview:
- Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake on the input and on every output channel.
- Each input word is routed by a select value to one of NUM_OUT channels.
- Each channel has a one-entry output slot, so one channel stalling does not block traffic to free channels.
- Sits between a single producer and NUM_OUT independent consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- NUM_OUT, 8, number of output channels (2..64).
- SEL_W, $clog2(NUM_OUT), select width; derived, not overridden.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  WIDTH  input word.
- in_sel  in  SEL_W  target channel index.
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted this cycle when in_valid && in_ready.
- out_data  out  NUM_OUT*WIDTH  flattened per-channel words; channel k at [k*WIDTH +: WIDTH].
- out_valid  out  NUM_OUT  per-channel valid.
- out_ready  in  NUM_OUT  per-channel ready.
- err_sel  out  1  one-cycle pulse: a word with in_sel >= NUM_OUT was accepted and dropped.
- drop_cnt  out  CNT_W  saturating count of dropped words.

Behaviour:
- Reset is synchronous and active-high on clk. On reset:
  - out_valid = 0, out_data = 0, err_sel = 0, drop_cnt = 0.
  - Words already buffered are discarded. Reset mid-transfer loses them silently.
- Slot k is free when out_valid[k] = 0, or when out_valid[k] && out_ready[k] in the same cycle (drain and refill together).
- in_ready (combinational from in_sel, out_valid, out_ready):
  - = free(in_sel) when in_sel < NUM_OUT.
  - = 1 when in_sel >= NUM_OUT (sink and drop).
- Accept: in_valid && in_ready at edge N.
  - Valid sel: slot[in_sel] loads in_data and out_valid[in_sel] is 1 after edge N. Latency is 1 cycle.
  - Invalid sel: nothing is stored. err_sel = 1 for the cycle after edge N. drop_cnt increments and saturates at 2^CNT_W-1.
- Output handshake, per channel:
  - out_valid[k] stays high and out_data[k] stays stable until out_ready[k] is sampled high.
  - Transfer with no new load clears out_valid[k]. out_data[k] keeps its last value; it is not zeroed.
- Simultaneous drain of slot k and accept into slot k: out_valid[k] stays 1 and data updates. One word per cycle per channel is sustained.
- Slots are independent; at most one load per cycle across all channels.
- in_sel and in_data are ignored when in_valid = 0. in_ready may still toggle with in_sel; the producer must not depend on it being stable.
- No other state machine. The per-slot state is EMPTY / FULL, held in out_valid[k].

Optional Feature:
- Macro: DEMUX_STREAM_BROADCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - When in_bcast = 1: in_ready = AND of free(k) over all k, and an accept loads in_data into every slot in the same edge. in_sel is ignored, so no error is possible.
  - When in_bcast = 0: unicast behaviour as above.
- Undefined: no in_bcast port; unicast only.

Decomposition:
- Shared package demux_pkg (`include header for plain Verilog):
  - clog2 helper.
  - Default WIDTH/NUM_OUT/CNT_W constants.
  - Macro for the channel slice index expression.
- Sub-module demux_out_slot:
  - Ports: clk, rst, load, load_data, out_ready, out_valid, out_data, and combinational free.
  - Instantiated NUM_OUT times in a generate loop.
- Top level holds select decode, in_ready mux, error pulse and drop counter.

Test Plan:
- Reset then idle, NUM_OUT=8, WIDTH=8:
  - out_valid = 8'h00, drop_cnt = 0, in_ready = 1 for every in_sel 0..7.
- Route in_sel=3, in_data=8'hA5, out_ready=0:
  - next cycle out_valid = 8'h08, out_data[31:24] = 8'hA5.
  - second word to sel 3 sees in_ready = 0.
  - word to sel 5 accepted, and out_valid becomes 8'h28.
- Back-to-back to sel 2 with out_ready[2] = 1 for 10 cycles, data 1..10:
  - in_ready stays 1.
  - channel 2 delivers 1..10 in order, one per cycle, no bubbles.
- NUM_OUT=6, in_sel=7, in_valid=1:
  - in_ready = 1, err_sel pulses one cycle, drop_cnt = 1, out_valid unchanged.
  - 300 such words with CNT_W=8 give drop_cnt = 255.
- Fill slots 0, 1, 4, then assert rst for one cycle mid-stream:
  - out_valid = 0 and drop_cnt = 0 the cycle after.
  - stale data is never presented with out_valid high.
- With DEMUX_STREAM_BROADCAST_EN, in_bcast=1, data 8'h3C, all slots empty:
  - out_valid = 8'hFF and every slice = 8'h3C.
  - with slot 6 full and out_ready[6] = 0, in_ready = 0 until slot 6 drains.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants, clog2 helper and channel slice macro for the stream demux
`ifndef DEMUX_PKG_SV
`define DEMUX_PKG_SV

// Bit range of channel k inside a flattened NUM_OUT*w bus
`define DEMUX_SLICE(k, w) (k)*(w) +: (w)

package demux_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_OUT = 8;
  localparam int DEF_CNT_W   = 8;

  // Smallest r with 2**r >= n; used to size the select field
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

`endif

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry output slot with valid/ready drain and same-cycle refill
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             free
);

  // Slot can take a word when empty or when its current word leaves this cycle
  assign free = !out_valid || out_ready;

  // EMPTY/FULL state lives in out_valid; data is held after a drain, never zeroed
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream_1ton.sv
// rtl/demux_stream_1ton.sv - registered 1-to-N stream demux; optional broadcast via DEMUX_STREAM_BROADCAST_EN
module demux_stream_1ton
  import demux_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int NUM_OUT = DEF_NUM_OUT,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int SEL_W   = clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
`ifdef DEMUX_STREAM_BROADCAST_EN
  input  logic                     in_bcast,
`endif
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic                     err_sel,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int             NPAD      = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W+1)'(NUM_OUT);

  logic               bcast;
  logic               sel_ok;
  logic               accept;
  logic               drop;
  logic [NUM_OUT-1:0] free;
  logic [NUM_OUT-1:0] load;
  logic [NPAD-1:0]    free_pad;

`ifdef DEMUX_STREAM_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign sel_ok = {1'b0, in_sel} < NUM_OUT_L;

  // Widen free to the full select range so out-of-range selects read a defined bit
  always_comb begin
    free_pad              = '0;
    free_pad[NUM_OUT-1:0] = free;
  end

  // Ready: all slots free for broadcast, target slot free for unicast, always for a dropped select
  always_comb begin
    in_ready = 1'b1;
    if (bcast) begin
      in_ready = &free;
    end else if (sel_ok) begin
      in_ready = free_pad[in_sel];
    end
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && !bcast && !sel_ok;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    assign load[k] = accept && (bcast || (in_sel == SEL_W'(k)));

    demux_out_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .load_data(in_data),
      .out_ready(out_ready[k]),
      .out_valid(out_valid[k]),
      .out_data (out_data[`DEMUX_SLICE(k, WIDTH)]),
      .free     (free[k])
    );
  end

  // One-cycle error pulse and saturating drop counter for accepted out-of-range words
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_sel <= drop;
      if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// tb/tb_demux_stream_1ton.sv - self-checking bench for demux_stream_1ton (8- and 6-channel instances)
module tb_demux_stream_1ton;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [2:0]  a_sel;
  logic [7:0]  a_data;
  logic        a_valid, a_ready, a_err;
  logic [63:0] a_odata;
  logic [7:0]  a_ovalid, a_ordy, a_cnt;

  logic [2:0]  b_sel;
  logic [7:0]  b_data;
  logic        b_valid, b_ready, b_err;
  logic [47:0] b_odata;
  logic [5:0]  b_ovalid, b_ordy;
  logic [7:0]  b_cnt;

`ifdef DEMUX_STREAM_BROADCAST_EN
  logic a_bc, b_bc;
`endif

  demux_stream_1ton #(.WIDTH(8), .NUM_OUT(8), .CNT_W(8)) u_a (
    .clk      (clk),
    .rst      (rst),
    .in_data  (a_data),
    .in_sel   (a_sel),
    .in_valid (a_valid),
`ifdef DEMUX_STREAM_BROADCAST_EN
    .in_bcast (a_bc),
`endif
    .in_ready (a_ready),
    .out_data (a_odata),
    .out_valid(a_ovalid),
    .out_ready(a_ordy),
    .err_sel  (a_err),
    .drop_cnt (a_cnt)
  );

  demux_stream_1ton #(.WIDTH(8), .NUM_OUT(6), .CNT_W(8)) u_b (
    .clk      (clk),
    .rst      (rst),
    .in_data  (b_data),
    .in_sel   (b_sel),
    .in_valid (b_valid),
`ifdef DEMUX_STREAM_BROADCAST_EN
    .in_bcast (b_bc),
`endif
    .in_ready (b_ready),
    .out_data (b_odata),
    .out_valid(b_ovalid),
    .out_ready(b_ordy),
    .err_sel  (b_err),
    .drop_cnt (b_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic       valid;
    logic [7:0] ordy;
    logic       exp_rdy;
    logic [7:0] exp_ov;
    int         ch;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl[5];

  // Reference model state: per-instance slot contents and drop bookkeeping
  logic       mv[2][8];
  logic [7:0] md[2][8];
  int         mcnt[2];
  logic       merr[2];
  logic [2:0] r_sel[2];
  logic [7:0] r_dat[2];
  logic       r_vld[2];
  logic [7:0] r_rdy[2];
  logic       r_bc[2];
  logic       e_rdy[2];

  function automatic int nout(input int u);
    return (u == 0) ? 8 : 6;
  endfunction

  function automatic logic model_ready(input int u);
    logic all_free;
    all_free = 1'b1;
    for (int k = 0; k < nout(u); k++) all_free &= (!mv[u][k] || r_rdy[u][k]);
    if (r_bc[u]) return all_free;
    if (int'(r_sel[u]) >= nout(u)) return 1'b1;
    return !mv[u][r_sel[u]] || r_rdy[u][r_sel[u]];
  endfunction

  task automatic model_edge(input int u, input logic acc);
    for (int k = 0; k < nout(u); k++) begin
      if (acc && (r_bc[u] || int'(r_sel[u]) == k)) begin
        mv[u][k] = 1'b1;
        md[u][k] = r_dat[u];
      end else if (r_rdy[u][k]) begin
        mv[u][k] = 1'b0;
      end
    end
    merr[u] = acc && !r_bc[u] && (int'(r_sel[u]) >= nout(u));
    if (merr[u] && mcnt[u] < 255) mcnt[u]++;
  endtask

  initial begin
    logic [63:0] e_od;
    logic [7:0]  e_ov;
    rst = 1'b1;
    a_sel = '0; a_data = '0; a_valid = 1'b0; a_ordy = '0;
    b_sel = '0; b_data = '0; b_valid = 1'b0; b_ordy = '0;
`ifdef DEMUX_STREAM_BROADCAST_EN
    a_bc = 1'b0; b_bc = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    chk("reset_ovalid", 64'(a_ovalid), 64'h0);
    chk("reset_odata", a_odata, 64'h0);
    chk("reset_cnt", 64'(a_cnt), 64'h0);
    chk("reset_err", 64'(a_err), 64'h0);
    for (int i = 0; i < 8; i++) begin
      a_sel = 3'(i);
      #1;
      chk("reset_ready", 64'(a_ready), 64'h1);
    end

    // Routing and stall table on the 8-channel instance
    tbl[0] = '{3'd3, 8'hA5, 1'b1, 8'h00, 1'b1, 8'h08, 3, 8'hA5};
    tbl[1] = '{3'd3, 8'h11, 1'b1, 8'h00, 1'b0, 8'h08, 3, 8'hA5};
    tbl[2] = '{3'd5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'h28, 5, 8'h5A};
    tbl[3] = '{3'd3, 8'h22, 1'b1, 8'h08, 1'b1, 8'h28, 3, 8'h22};
    tbl[4] = '{3'd0, 8'hEE, 1'b0, 8'hFF, 1'b1, 8'h00, 5, 8'h5A};
    for (int i = 0; i < 5; i++) begin
      a_sel = tbl[i].sel; a_data = tbl[i].data; a_valid = tbl[i].valid; a_ordy = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(a_ready), 64'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("tbl%0d_ovalid", i), 64'(a_ovalid), 64'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_data", i), 64'(a_odata[tbl[i].ch*8 +: 8]), 64'(tbl[i].exp_d));
    end

    // Back-to-back stream on channel 2 with a consumer that is always ready
    a_ordy = 8'h04;
    for (int i = 1; i <= 10; i++) begin
      a_sel = 3'd2; a_data = 8'(i); a_valid = 1'b1;
      #1;
      chk("b2b_ready", 64'(a_ready), 64'h1);
      tick();
      chk("b2b_valid", 64'(a_ovalid), 64'h04);
      chk("b2b_data", 64'(a_odata[23:16]), 64'(i));
    end
    a_valid = 1'b0;
    tick();
    chk("b2b_drained", 64'(a_ovalid), 64'h0);

    // Out-of-range selects on the 6-channel instance
    b_sel = 3'd7; b_valid = 1'b1; b_data = 8'h12;
    #1;
    chk("drop7_ready", 64'(b_ready), 64'h1);
    tick();
    chk("drop7_err", 64'(b_err), 64'h1);
    chk("drop7_cnt", 64'(b_cnt), 64'h1);
    chk("drop7_ovalid", 64'(b_ovalid), 64'h0);
    b_sel = 3'd6;
    #1;
    chk("drop6_ready", 64'(b_ready), 64'h1);
    tick();
    chk("drop6_cnt", 64'(b_cnt), 64'h2);
    b_valid = 1'b0;
    tick();
    chk("drop_err_pulse", 64'(b_err), 64'h0);
    b_sel = 3'd5; b_valid = 1'b1; b_data = 8'h77;
    tick();
    chk("sel5_ovalid", 64'(b_ovalid), 64'h20);
    chk("sel5_err", 64'(b_err), 64'h0);
    chk("sel5_data", 64'(b_odata[47:40]), 64'h77);
    b_valid = 1'b0; b_ordy = '1;
    tick();
    b_ordy = '0; b_sel = 3'd7; b_valid = 1'b1;
    for (int i = 0; i < 298; i++) tick();
    chk("sat_cnt", 64'(b_cnt), 64'd255);
    chk("sat_err", 64'(b_err), 64'h1);
    b_valid = 1'b0;
    tick();
    chk("sat_hold", 64'(b_cnt), 64'd255);

    // Mid-stream reset discards buffered words
    a_ordy = '0; a_valid = 1'b1;
    a_sel = 3'd0; a_data = 8'h10; tick();
    a_sel = 3'd1; a_data = 8'h11; tick();
    a_sel = 3'd4; a_data = 8'h14; tick();
    chk("prereset_ovalid", 64'(a_ovalid), 64'h13);
    rst = 1'b1; a_sel = 3'd2; a_data = 8'h99;
    tick();
    rst = 1'b0; a_valid = 1'b0;
    chk("midreset_ovalid", 64'(a_ovalid), 64'h0);
    chk("midreset_odata", a_odata, 64'h0);
    chk("midreset_cnt", 64'(b_cnt), 64'h0);
    tick();
    chk("postreset_ovalid", 64'(a_ovalid), 64'h0);

    // Randomized traffic on both instances against the reference model
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 8; k++) begin
        mv[u][k] = 1'b0;
        md[u][k] = '0;
      end
      mcnt[u] = 0;
      merr[u] = 1'b0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int u = 0; u < 2; u++) begin
        r_sel[u] = 3'($urandom_range(0, 7));
        r_dat[u] = 8'($urandom);
        r_vld[u] = ($urandom_range(0, 3) != 0);
        r_rdy[u] = 8'($urandom);
        r_bc[u]  = 1'b0;
`ifdef DEMUX_STREAM_BROADCAST_EN
        r_bc[u]  = ($urandom_range(0, 7) == 0);
`endif
      end
      a_sel = r_sel[0]; a_data = r_dat[0]; a_valid = r_vld[0]; a_ordy = r_rdy[0];
      b_sel = r_sel[1]; b_data = r_dat[1]; b_valid = r_vld[1]; b_ordy = r_rdy[1][5:0];
`ifdef DEMUX_STREAM_BROADCAST_EN
      a_bc = r_bc[0]; b_bc = r_bc[1];
`endif
      #1;
      for (int u = 0; u < 2; u++) begin
        e_rdy[u] = model_ready(u);
        chk($sformatf("rnd%0d_ready", u), 64'((u == 0) ? a_ready : b_ready), 64'(e_rdy[u]));
      end
      tick();
      for (int u = 0; u < 2; u++) begin
        model_edge(u, r_vld[u] && e_rdy[u]);
        e_od = '0;
        e_ov = '0;
        for (int k = 0; k < nout(u); k++) begin
          e_od[k*8 +: 8] = md[u][k];
          e_ov[k]        = mv[u][k];
        end
        chk($sformatf("rnd%0d_ovalid", u), (u == 0) ? 64'(a_ovalid) : 64'(b_ovalid), 64'(e_ov));
        chk($sformatf("rnd%0d_odata", u), (u == 0) ? a_odata : 64'(b_odata), e_od);
        chk($sformatf("rnd%0d_err", u), 64'((u == 0) ? a_err : b_err), 64'(merr[u]));
        chk($sformatf("rnd%0d_cnt", u), (u == 0) ? 64'(a_cnt) : 64'(b_cnt), 64'(mcnt[u]));
      end
    end

`ifdef DEMUX_STREAM_BROADCAST_EN
    // Broadcast fill, then stall behind a single full slot
    a_valid = 1'b0; b_valid = 1'b0; a_bc = 1'b0; b_bc = 1'b0;
    a_ordy = '1; b_ordy = '1;
    tick();
    chk("bc_empty", 64'(a_ovalid), 64'h0);
    a_ordy = '0; a_bc = 1'b1; a_valid = 1'b1; a_data = 8'h3C; a_sel = 3'd0;
    #1;
    chk("bc_ready_empty", 64'(a_ready), 64'h1);
    tick();
    chk("bc_ovalid", 64'(a_ovalid), 64'hFF);
    chk("bc_odata", a_odata, {8{8'h3C}});
    a_valid = 1'b0; a_ordy = 8'hBF;
    tick();
    chk("bc_slot6_only", 64'(a_ovalid), 64'h40);
    a_ordy = '0; a_valid = 1'b1; a_data = 8'hC3;
    #1;
    chk("bc_ready_blocked", 64'(a_ready), 64'h0);
    tick();
    chk("bc_blocked_ovalid", 64'(a_ovalid), 64'h40);
    chk("bc_blocked_data", 64'(a_odata[55:48]), 64'h3C);
    a_ordy = 8'h40;
    #1;
    chk("bc_ready_drain", 64'(a_ready), 64'h1);
    tick();
    chk("bc_refill_ovalid", 64'(a_ovalid), 64'hFF);
    chk("bc_refill_odata", a_odata, {8{8'hC3}});
    a_valid = 1'b0; a_bc = 1'b0;
    b_ordy = '0; b_bc = 1'b1; b_sel = 3'd7; b_valid = 1'b1; b_data = 8'h05;
    tick();
    chk("bc_noerr", 64'(b_err), 64'h0);
    chk("bc_b_ovalid", 64'(b_ovalid), 64'h3F);
    b_valid = 1'b0; b_bc = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
